// File: rtl/multisymbol_carry_normalize_pkg.sv
// Shared types and helpers for the multi-symbol carry normaliser.
package multisymbol_carry_normalize_pkg;

  localparam int CARRYBITS_DEFAULT = 8;

  // Normalised symbol width: one radix digit plus room for the incoming carry.
  function automatic int symnorm_outwidth(input int logradix);
    return logradix + 2;
  endfunction

  typedef struct packed {
    logic valid;
    logic ready;
  } hs_t;

endpackage

// File: rtl/multisymbol_carry_normalize_symbol_carry_add.sv
// One lane of the normaliser: adds the neighbour's carry digit to this lane's low digit.
module symbol_carry_add
  import multisymbol_carry_normalize_pkg::*;
#(
  parameter int LOGRADIX  = 33,
  parameter int CARRYBITS = CARRYBITS_DEFAULT
) (
  input  logic [LOGRADIX-1:0]  lo,
  input  logic [CARRYBITS-1:0] hi,
  output logic [LOGRADIX+1:0]  sum
);

  localparam int OUTW = symnorm_outwidth(LOGRADIX);

  assign sum = OUTW'(lo) + OUTW'(hi);

endmodule

// File: rtl/multisymbol_carry_normalize.sv
// Two-stage valid/ready carry-save normalisation of wide adder-tree symbols.
// Optional sticky overflow flag built only when SYMNORM_OVF_STICKY_EN is defined.
// CARRYBITS must not exceed LOGRADIX, otherwise a lane sum can reach the top bit.
module multisymbol_carry_normalize
  import multisymbol_carry_normalize_pkg::*;
#(
  parameter int LOGNUMSYMBOLS = 5,
  parameter int LOGRADIX      = 33,
  parameter int CARRYBITS     = CARRYBITS_DEFAULT,
  localparam int NUMSYMBOLS   = 1 << LOGNUMSYMBOLS
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  input  logic [NUMSYMBOLS-1:0][LOGRADIX+CARRYBITS-1:0]   sym_in,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [NUMSYMBOLS-1:0][LOGRADIX+1:0]             sym_out,
  output logic [CARRYBITS-1:0]                            carry_out,
  input  logic                                            ovf_clr,
  output logic                                            ovf_sticky
);

  localparam int SYMW = LOGRADIX + CARRYBITS;
  localparam int OUTW = symnorm_outwidth(LOGRADIX);

  logic                              s1_valid;
  logic                              s2_valid;
  logic [NUMSYMBOLS-1:0][SYMW-1:0]   s1_sym;
  logic [NUMSYMBOLS-1:0][OUTW-1:0]   lane_sum;
  hs_t                               in_hs;
  hs_t                               out_hs;
  logic                              adv2;

  assign out_hs    = '{valid: s2_valid, ready: out_ready};
  assign adv2      = !out_hs.valid || out_hs.ready;
  assign in_ready  = !s1_valid || adv2;
  assign in_hs     = '{valid: in_valid, ready: in_ready};
  assign out_valid = s2_valid;

  // Lane 0 has no lower neighbour, so it never receives a carry digit.
  for (genvar i = 0; i < NUMSYMBOLS; i++) begin : g_lane
    if (i == 0) begin : g_ls
      symbol_carry_add #(.LOGRADIX(LOGRADIX), .CARRYBITS(CARRYBITS)) u_add (
        .lo  (s1_sym[i][LOGRADIX-1:0]),
        .hi  ({CARRYBITS{1'b0}}),
        .sum (lane_sum[i])
      );
    end else begin : g_up
      symbol_carry_add #(.LOGRADIX(LOGRADIX), .CARRYBITS(CARRYBITS)) u_add (
        .lo  (s1_sym[i][LOGRADIX-1:0]),
        .hi  (s1_sym[i-1][SYMW-1:LOGRADIX]),
        .sum (lane_sum[i])
      );
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sym   <= '0;
    end else if (in_hs.ready) begin
      s1_valid <= in_hs.valid;
      if (in_hs.valid) s1_sym <= sym_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      sym_out   <= '0;
      carry_out <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        sym_out   <= lane_sum;
        carry_out <= s1_sym[NUMSYMBOLS-1][SYMW-1:LOGRADIX];
      end
    end
  end

`ifdef SYMNORM_OVF_STICKY_EN
  // Set has priority so an overflow landing on the clear cycle is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
    end else if (out_hs.valid && out_hs.ready && (carry_out != '0)) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end
`else
  logic ovf_clr_unused;
  assign ovf_clr_unused = ovf_clr;
  assign ovf_sticky     = 1'b0;
`endif

endmodule

// File: tb/tb_multisymbol_carry_normalize.sv
// Scoreboard bench: small-parameter instance for directed scenarios, default-parameter
// instance for a long random run checked against a wide-integer invariant.
module tb_multisymbol_carry_normalize;

  localparam int SLN = 2, SLR = 4, SCB = 4;
  localparam int SN = 4, SSW = 8, SOW = 6;
  localparam int BLN = 5, BLR = 33, BCB = 8;
  localparam int BN = 32, BSW = 41, BOW = 35;
  localparam int BIG = 1100;

`ifdef SYMNORM_OVF_STICKY_EN
  localparam logic EXP_STICKY = 1'b1;
`else
  localparam logic EXP_STICKY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic                      s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b1;
  logic [SN-1:0][SSW-1:0]    s_sym_in = '0;
  logic [SN-1:0][SOW-1:0]    s_sym_out;
  logic [SCB-1:0]            s_carry_out;
  logic                      s_ovf_clr = 1'b0, s_ovf_sticky;

  logic                      b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1;
  logic [BN-1:0][BSW-1:0]    b_sym_in = '0;
  logic [BN-1:0][BOW-1:0]    b_sym_out;
  logic [BCB-1:0]            b_carry_out;
  logic                      b_ovf_sticky;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int s_pops = 0;
  int b_pops = 0;
  logic [SN-1:0][SSW-1:0] s_q[$];
  logic [BN-1:0][BSW-1:0] b_q[$];
  int pop_cyc[$];

  multisymbol_carry_normalize #(.LOGNUMSYMBOLS(SLN), .LOGRADIX(SLR), .CARRYBITS(SCB)) u_small (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .sym_in(s_sym_in), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .sym_out(s_sym_out), .carry_out(s_carry_out), .ovf_clr(s_ovf_clr), .ovf_sticky(s_ovf_sticky)
  );

  multisymbol_carry_normalize #(.LOGNUMSYMBOLS(BLN), .LOGRADIX(BLR), .CARRYBITS(BCB)) u_big (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .sym_in(b_sym_in), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .sym_out(b_sym_out), .carry_out(b_carry_out), .ovf_clr(1'b0), .ovf_sticky(b_ovf_sticky)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [SN-1:0][SOW-1:0] s_model(input logic [SN-1:0][SSW-1:0] w);
    logic [SN-1:0][SOW-1:0] r;
    for (int i = 0; i < SN; i++) begin
      r[i] = SOW'(w[i][SLR-1:0]);
      if (i > 0) r[i] = r[i] + SOW'(w[i-1][SSW-1:SLR]);
    end
    return r;
  endfunction

  function automatic int s_in_val(input logic [SN-1:0][SSW-1:0] w);
    int a = 0;
    for (int i = 0; i < SN; i++) a += int'(w[i]) << (SLR * i);
    return a;
  endfunction

  function automatic int s_out_val(input logic [SN-1:0][SOW-1:0] o, input logic [SCB-1:0] c);
    int a = int'(c) << (SLR * SN);
    for (int i = 0; i < SN; i++) a += int'(o[i]) << (SLR * i);
    return a;
  endfunction

  function automatic logic [BIG-1:0] b_in_val(input logic [BN-1:0][BSW-1:0] w);
    logic [BIG-1:0] a = '0;
    for (int i = 0; i < BN; i++) a += BIG'(w[i]) << (BLR * i);
    return a;
  endfunction

  function automatic logic [BIG-1:0] b_out_val(input logic [BN-1:0][BOW-1:0] o, input logic [BCB-1:0] c);
    logic [BIG-1:0] a = BIG'(c) << (BLR * BN);
    for (int i = 0; i < BN; i++) a += BIG'(o[i]) << (BLR * i);
    return a;
  endfunction

  task automatic run_monitors();
    fork
      forever begin : mon
        logic [SN-1:0][SSW-1:0] sw;
        logic [SN-1:0][SOW-1:0] sexp;
        logic [BN-1:0][BSW-1:0] bw;
        logic [BIG-1:0]         bexp, bgot;
        logic                   msb_bad;
        @(negedge clk);
        if (rst_n) begin
          if (s_out_valid && s_out_ready) begin
            checks++;
            if (s_q.size() == 0) begin
              errors++;
              $display("FAIL small_spurious_output sym_out=%h carry=%h expected no output", s_sym_out, s_carry_out);
            end else begin
              sw = s_q.pop_front();
              sexp = s_model(sw);
              s_pops++;
              pop_cyc.push_back(cyc);
              if (s_sym_out !== sexp || s_carry_out !== sw[SN-1][SSW-1:SLR]) begin
                errors++;
                $display("FAIL small_data sym_out=%h carry=%h expected sym_out=%h carry=%h",
                         s_sym_out, s_carry_out, sexp, sw[SN-1][SSW-1:SLR]);
              end
              checks++;
              if (s_out_val(s_sym_out, s_carry_out) != s_in_val(sw)) begin
                errors++;
                $display("FAIL small_invariant got %0d expected %0d",
                         s_out_val(s_sym_out, s_carry_out), s_in_val(sw));
              end
            end
          end
          if (s_in_valid && s_in_ready) s_q.push_back(s_sym_in);

          if (b_out_valid && b_out_ready) begin
            checks++;
            if (b_q.size() == 0) begin
              errors++;
              $display("FAIL big_spurious_output carry=%h expected no output", b_carry_out);
            end else begin
              bw = b_q.pop_front();
              b_pops++;
              bexp = b_in_val(bw);
              bgot = b_out_val(b_sym_out, b_carry_out);
              msb_bad = 1'b0;
              for (int i = 0; i < BN; i++) if (b_sym_out[i][BOW-1]) msb_bad = 1'b1;
              if (bgot !== bexp || msb_bad) begin
                errors++;
                $display("FAIL big_invariant word %0d got[255:0]=%h expected[255:0]=%h msb_set=%0b",
                         b_pops, bgot[255:0], bexp[255:0], msb_bad);
              end
            end
          end
          if (b_in_valid && b_in_ready) b_q.push_back(b_sym_in);
        end
      end
    join_none
  endtask

  task automatic s_send(input logic [SN-1:0][SSW-1:0] w, output int waited);
    logic acc;
    s_in_valid = 1'b1;
    s_sym_in   = w;
    waited     = 0;
    while (1) begin
      @(negedge clk);
      acc = s_in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      waited++;
      if (waited > 50) begin
        checks++;
        errors++;
        $display("FAIL small_send_timeout waited=%0d expected <=50", waited);
        break;
      end
    end
  endtask

  task automatic s_drain();
    s_in_valid = 1'b0;
    for (int k = 0; k < 60 && s_q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (s_q.size() != 0) begin
      errors++;
      $display("FAIL small_drain_timeout pending=%0d expected 0", s_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (s_out_valid !== 1'b0 || s_sym_out !== '0 || s_carry_out !== '0 ||
        s_ovf_sticky !== 1'b0 || b_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state out_valid=%b sym_out=%h carry=%h sticky=%b big_valid=%b expected all 0",
               s_out_valid, s_sym_out, s_carry_out, s_ovf_sticky, b_out_valid);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (s_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready small=%b big=%b expected 1", s_in_ready, b_in_ready);
    end
  endtask

  task automatic test_basic();
    logic [SN-1:0][SSW-1:0] w;
    int waited;
    s_out_ready = 1'b1;
    w = '0;
    w[0] = 8'h15;
    s_send(w, waited);
    s_in_valid = 1'b0;
    checks++;
    if (waited != 0 || s_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency1 waited=%0d out_valid=%b expected 0 and 0", waited, s_out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (s_out_valid !== 1'b1 || s_sym_out !== {6'h00, 6'h00, 6'h01, 6'h05} || s_carry_out !== 4'h0) begin
      errors++;
      $display("FAIL basic_result valid=%b sym_out=%h carry=%h expected 1 %h 0",
               s_out_valid, s_sym_out, s_carry_out, {6'h00, 6'h00, 6'h01, 6'h05});
    end
    s_drain();
  endtask

  task automatic test_all_ones();
    logic [SN-1:0][SSW-1:0] w;
    int waited;
    w = '1;
    s_send(w, waited);
    s_in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (s_out_valid !== 1'b1 || s_sym_out !== {6'h1E, 6'h1E, 6'h1E, 6'h0F} ||
        s_carry_out !== 4'hF || s_ovf_sticky !== 1'b0) begin
      errors++;
      $display("FAIL all_ones valid=%b sym_out=%h carry=%h sticky=%b expected 1 %h f 0",
               s_out_valid, s_sym_out, s_carry_out, s_ovf_sticky, {6'h1E, 6'h1E, 6'h1E, 6'h0F});
    end
    @(posedge clk);
    #1;
    checks++;
    if (s_ovf_sticky !== EXP_STICKY) begin
      errors++;
      $display("FAIL sticky_set got %b expected %b", s_ovf_sticky, EXP_STICKY);
    end
    s_ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    s_ovf_clr = 1'b0;
    checks++;
    if (s_ovf_sticky !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clear got %b expected 0", s_ovf_sticky);
    end
    s_send(w, waited);
    s_in_valid = 1'b0;
    @(posedge clk);
    #1;
    s_ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    s_ovf_clr = 1'b0;
    checks++;
    if (s_ovf_sticky !== EXP_STICKY) begin
      errors++;
      $display("FAIL sticky_set_wins got %b expected %b", s_ovf_sticky, EXP_STICKY);
    end
    s_drain();
    s_ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    s_ovf_clr = 1'b0;
  endtask

  task automatic test_stream();
    logic [SN-1:0][SSW-1:0] w;
    int waited, total_wait, base;
    s_out_ready = 1'b1;
    pop_cyc.delete();
    total_wait = 0;
    base = s_pops;
    for (int n = 0; n < 8; n++) begin
      w = {SN{8'(n * 37 + 11)}};
      w[0] = 8'($urandom_range(255));
      s_send(w, waited);
      total_wait += waited;
    end
    s_drain();
    checks++;
    if (total_wait != 0 || s_pops - base != 8) begin
      errors++;
      $display("FAIL stream_count stalls=%0d outputs=%0d expected 0 and 8", total_wait, s_pops - base);
    end
    checks++;
    for (int n = 1; n < pop_cyc.size(); n++) begin
      if (pop_cyc[n] != pop_cyc[0] + n) begin
        errors++;
        $display("FAIL stream_back_to_back output %0d at cycle %0d expected %0d", n, pop_cyc[n], pop_cyc[0] + n);
        break;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [SN-1:0][SSW-1:0] w[4];
    logic [SN-1:0][SOW-1:0] held;
    logic held_valid, unstable, acc;
    int idx, waited, base;
    for (int n = 0; n < 4; n++) w[n] = {8'($urandom_range(255)), 8'(n), 8'hA5, 8'($urandom_range(255))};
    base = s_pops;
    s_out_ready = 1'b0;
    idx = 0;
    held_valid = 1'b0;
    unstable = 1'b0;
    held = '0;
    for (int c = 0; c < 5; c++) begin
      s_in_valid = 1'b1;
      s_sym_in = w[idx];
      @(negedge clk);
      acc = s_in_ready;
      if (s_out_valid) begin
        if (held_valid && s_sym_out !== held) unstable = 1'b1;
        held = s_sym_out;
        held_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    checks++;
    if (idx != 2 || s_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accepts accepted=%0d in_ready=%b expected 2 and 0", idx, s_in_ready);
    end
    checks++;
    if (unstable || !held_valid) begin
      errors++;
      $display("FAIL bp_hold unstable=%b seen_valid=%b expected 0 and 1", unstable, held_valid);
    end
    s_out_ready = 1'b1;
    while (idx < 4) begin
      s_send(w[idx], waited);
      idx++;
    end
    s_drain();
    checks++;
    if (s_pops - base != 4) begin
      errors++;
      $display("FAIL bp_no_loss outputs=%0d expected 4", s_pops - base);
    end
  endtask

  task automatic test_reset_midflight();
    logic [SN-1:0][SSW-1:0] w;
    int waited, base;
    s_out_ready = 1'b0;
    s_send({8'h11, 8'h22, 8'h33, 8'h44}, waited);
    s_send({8'h55, 8'h66, 8'h77, 8'h88}, waited);
    s_in_valid = 1'b0;
    checks++;
    if (s_out_valid !== 1'b1 || s_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_full out_valid=%b in_ready=%b expected 1 and 0", s_out_valid, s_in_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (s_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_flush out_valid=%b expected 0", s_out_valid);
    end
    s_q.delete();
    base = s_pops;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    s_out_ready = 1'b1;
    #1;
    checks++;
    if (s_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ready in_ready=%b expected 1", s_in_ready);
    end
    w = {8'h9C, 8'h03, 8'hF0, 8'h2B};
    s_send(w, waited);
    s_drain();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (s_pops - base != 1) begin
      errors++;
      $display("FAIL midreset_alone outputs=%0d expected 1", s_pops - base);
    end
  endtask

  task automatic test_random_big();
    int sent, base;
    logic acc;
    sent = 0;
    base = b_pops;
    for (int c = 0; c < 20000 && (sent < 2000 || b_q.size() != 0); c++) begin
      if (!b_in_valid && sent < 2000 && $urandom_range(3) != 0) begin
        b_in_valid = 1'b1;
        for (int i = 0; i < BN; i++) begin
          b_sym_in[i] = BSW'({$urandom(), $urandom()});
          if ($urandom_range(7) == 0) b_sym_in[i] = '1;
        end
      end
      b_out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      acc = b_in_valid && b_in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        sent++;
        b_in_valid = 1'b0;
      end
    end
    b_in_valid = 1'b0;
    b_out_ready = 1'b1;
    checks++;
    if (sent != 2000 || b_q.size() != 0 || b_pops - base != 2000) begin
      errors++;
      $display("FAIL big_random sent=%0d pending=%0d outputs=%0d expected 2000 0 2000",
               sent, b_q.size(), b_pops - base);
    end
  endtask

  initial begin
    run_monitors();
    test_reset();
    test_basic();
    test_all_ones();
    test_stream();
    test_backpressure();
    test_reset_midflight();
    test_random_big();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
